// File: rtl/led_chaser8.sv
// led_chaser8: switch-selected rate and pattern mode drive a registered LED chaser.
// Define LED_CHASER_DEBOUNCE_EN to require DEB_CYCLES of stable switches before acceptance.
module led_chaser8 #(
  parameter int unsigned W          = 8,
  parameter int unsigned DEB_CYCLES = 500000,
  parameter int unsigned DEB_BITS   = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   rate_in,
  input  logic [3:0]   sw,
  output logic [W-1:0] led,
  output logic         step
);

  localparam logic [1:0] MODE_ROTL   = 2'b00;
  localparam logic [1:0] MODE_ROTR   = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_FILL   = 2'b11;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
  localparam logic PH_FILL   = 1'b0;
  localparam logic PH_CLEAR  = 1'b1;

  if (W < 2 || DEB_CYCLES == 0 || (DEB_CYCLES >> DEB_BITS) != 0) begin : g_bad_params
    $error("led_chaser8: need W >= 2, DEB_CYCLES > 0 and 2**DEB_BITS > DEB_CYCLES");
  end

  logic [3:0]   sync1_q, sync2_q;
  logic [3:0]   sw_s;
  logic [3:0]   sw_q, sw_q_d;
  logic         sel;
  logic         prev_q, prev_d;
  logic         step_q, step_d;
  logic [W-1:0] led_q, led_d;
  logic         dir_q, dir_d;
  logic         phase_q, phase_d;

  assign sw_s = sync2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sw;
      sync2_q <= sync1_q;
    end
  end

`ifdef LED_CHASER_DEBOUNCE_EN
  logic [DEB_BITS-1:0] deb_cnt_q, deb_cnt_d;
  logic [3:0]          sw_s_last_q;

  // Count only while sw_s differs from the accepted value and has not moved since last cycle.
  always_comb begin
    sw_q_d    = sw_q;
    deb_cnt_d = '0;
    if (sw_s != sw_q && sw_s == sw_s_last_q) begin
      if (deb_cnt_q == DEB_BITS'(DEB_CYCLES - 1)) begin
        sw_q_d = sw_s;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_cnt_q   <= '0;
      sw_s_last_q <= '0;
    end else begin
      deb_cnt_q   <= deb_cnt_d;
      sw_s_last_q <= sw_s;
    end
  end
`else
  always_comb begin
    sw_q_d = sw_s;
  end
`endif

  // Reloads key off sw_q_d so the pattern reloads on the same edge that sw_q is accepted.
  always_comb begin
    sel     = rate_in[sw_q[1:0]];
    prev_d  = sel;
    if (sw_q_d[1:0] != sw_q[1:0]) begin
      prev_d = rate_in[sw_q_d[1:0]];
    end
    step_d  = sel & ~prev_q;

    led_d   = led_q;
    dir_d   = dir_q;
    phase_d = phase_q;
    if (sw_q_d[3:2] != sw_q[3:2]) begin
      case (sw_q_d[3:2])
        MODE_ROTR: led_d = {1'b1, {(W-1){1'b0}}};
        MODE_FILL: led_d = '0;
        default:   led_d = W'(1);
      endcase
      dir_d   = DIR_LEFT;
      phase_d = PH_FILL;
    end else if (step_q) begin
      case (sw_q[3:2])
        MODE_ROTL: led_d = {led_q[W-2:0], led_q[W-1]};
        MODE_ROTR: led_d = {led_q[0], led_q[W-1:1]};
        MODE_BOUNCE: begin
          if (dir_q == DIR_LEFT && led_q[W-1]) begin
            dir_d = DIR_RIGHT;
            led_d = {1'b0, led_q[W-1:1]};
          end else if (dir_q == DIR_RIGHT && led_q[0]) begin
            dir_d = DIR_LEFT;
            led_d = {led_q[W-2:0], 1'b0};
          end else if (dir_q == DIR_LEFT) begin
            led_d = {led_q[W-2:0], 1'b0};
          end else begin
            led_d = {1'b0, led_q[W-1:1]};
          end
        end
        default: begin
          if (phase_q == PH_FILL) begin
            led_d = {led_q[W-2:0], 1'b1};
            if (&led_d) phase_d = PH_CLEAR;
          end else begin
            led_d = {led_q[W-2:0], 1'b0};
            if (led_d == '0) phase_d = PH_FILL;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_q    <= '0;
      prev_q  <= 1'b0;
      step_q  <= 1'b0;
      led_q   <= W'(1);
      dir_q   <= DIR_LEFT;
      phase_q <= PH_FILL;
    end else begin
      sw_q    <= sw_q_d;
      prev_q  <= prev_d;
      step_q  <= step_d;
      led_q   <= led_d;
      dir_q   <= dir_d;
      phase_q <= phase_d;
    end
  end

  assign led  = led_q;
  assign step = step_q;

endmodule
